// File: rtl/hash_table_pkg.sv
// Shared op codes, sequencer states and request layout for the hash table front end.
package hash_table_pkg;

    localparam logic [1:0] OP_INSERT  = 2'b00;
    localparam logic [1:0] OP_DELETE  = 2'b01;
    localparam logic [1:0] OP_SEARCH  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int HT_KEY_WIDTH   = 32;
    localparam int HT_VALUE_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

    typedef struct packed {
        logic [1:0]                op;
        logic [HT_KEY_WIDTH-1:0]   key;
        logic [HT_VALUE_WIDTH-1:0] value;
    } req_t;

endpackage

// File: rtl/hash_req_fifo.sv
// Request FIFO: power-of-two depth, registered occupancy, wrap-around pointers.
module hash_req_fifo #(
    parameter type entry_t = hash_table_pkg::req_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/hash_table_req_sequencer.sv
// Queues hash table requests and issues them one at a time, with timeout and ordered responses.
//   state | meaning
//   IDLE  | look at FIFO head; legal op -> ISSUE, illegal op -> RESP with error
//   ISSUE | one-cycle ht_op_en strobe, timeout counter cleared
//   WAIT  | wait for ht_op_done or timeout
//   RESP  | hold response until rsp_ready, then pop the head
module hash_table_req_sequencer
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [KEY_WIDTH-1:0]   req_key_i,
    input  logic [VALUE_WIDTH-1:0] req_value_i,
    output logic                   ht_op_en_o,
    output logic [1:0]             ht_op_sel_o,
    output logic [KEY_WIDTH-1:0]   ht_key_o,
    output logic [VALUE_WIDTH-1:0] ht_value_o,
    input  logic [VALUE_WIDTH-1:0] ht_value_out_i,
    input  logic                   ht_op_done_i,
    input  logic                   ht_op_error_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [1:0]             rsp_op_o,
    output logic [VALUE_WIDTH-1:0] rsp_value_o,
    output logic                   rsp_error_o,
    output logic                   rsp_timeout_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [1:0]             op;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } req_w_t;

    seq_state_e             state_q;
    logic [TW-1:0]          tcnt_q;
    logic                   ht_op_en_q;
    logic [1:0]             ht_op_sel_q;
    logic [KEY_WIDTH-1:0]   ht_key_q;
    logic [VALUE_WIDTH-1:0] ht_value_q;
    logic                   rsp_valid_q;
    logic [1:0]             rsp_op_q;
    logic [VALUE_WIDTH-1:0] rsp_value_q;
    logic                   rsp_error_q;
    logic                   rsp_timeout_q;

    req_w_t push_data, head;
    logic   fifo_full, fifo_empty, pop;

    assign push_data   = '{op: req_op_i, key: req_key_i, value: req_value_i};
    assign req_ready_o = !fifo_full;
    assign pop         = (state_q == ST_RESP) && rsp_ready_i;

    hash_req_fifo #(
        .entry_t (req_w_t),
        .DEPTH   (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (req_valid_i),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            tcnt_q        <= '0;
            ht_op_en_q    <= 1'b0;
            ht_op_sel_q   <= '0;
            ht_key_q      <= '0;
            ht_value_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_op_q      <= '0;
            rsp_value_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        rsp_op_q <= head.op;
                        if (head.op == OP_ILLEGAL) begin
                            rsp_valid_q   <= 1'b1;
                            rsp_error_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_value_q   <= '0;
                            state_q       <= ST_RESP;
                        end else begin
                            ht_op_en_q  <= 1'b1;
                            ht_op_sel_q <= head.op;
                            ht_key_q    <= head.key;
                            ht_value_q  <= (head.op == OP_INSERT) ? head.value : '0;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    ht_op_en_q <= 1'b0;
                    tcnt_q     <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ht_op_done_i) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= ht_op_error_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_value_q   <= (ht_op_sel_q == OP_SEARCH && !ht_op_error_i)
                                         ? ht_value_out_i : '0;
                        state_q       <= ST_RESP;
                    end else if (tcnt_q == T_LAST) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_value_q   <= '0;
                        state_q       <= ST_RESP;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    // Command fields stay on the bus until the response is consumed.
                    if (rsp_ready_i) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_op_q      <= '0;
                        rsp_value_q   <= '0;
                        rsp_error_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        ht_op_sel_q   <= '0;
                        ht_key_q      <= '0;
                        ht_value_q    <= '0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ht_op_en_o    = ht_op_en_q;
    assign ht_op_sel_o   = ht_op_sel_q;
    assign ht_key_o      = ht_key_q;
    assign ht_value_o    = ht_value_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_op_o      = rsp_op_q;
    assign rsp_value_o   = rsp_value_q;
    assign rsp_error_o   = rsp_error_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_hash_table_req_sequencer.sv
// Directed and random checks of the request sequencer against a map-based reference model.
module tb_hash_table_req_sequencer;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i, req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_key_i, req_value_i;
    logic        ht_op_en_o;
    logic [1:0]  ht_op_sel_o;
    logic [31:0] ht_key_o, ht_value_o, ht_value_out_i;
    logic        ht_op_done_i, ht_op_error_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [1:0]  rsp_op_o;
    logic [31:0] rsp_value_o;
    logic        rsp_error_o, rsp_timeout_o;

    hash_table_req_sequencer #(
        .KEY_WIDTH(32), .VALUE_WIDTH(32), .QUEUE_DEPTH(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_key_i(req_key_i), .req_value_i(req_value_i),
        .ht_op_en_o(ht_op_en_o), .ht_op_sel_o(ht_op_sel_o), .ht_key_o(ht_key_o),
        .ht_value_o(ht_value_o), .ht_value_out_i(ht_value_out_i),
        .ht_op_done_i(ht_op_done_i), .ht_op_error_i(ht_op_error_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o),
        .rsp_value_o(rsp_value_o), .rsp_error_o(rsp_error_o), .rsp_timeout_o(rsp_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [1:0] op; logic [31:0] val; logic err; logic to;} exp_t;
    typedef struct packed {logic [1:0] op; logic [31:0] key; logic [31:0] val;} iss_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    iss_t        iss_q[$];
    logic [31:0] ref_map [logic [31:0]];
    logic [31:0] hm_map  [logic [31:0]];
    bit          hm_never = 1'b0;
    int          hm_lat   = 3;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: each accepted request yields one response, in order, from plain map semantics.
    task automatic ref_push(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                            input bit to);
        if (op == 2'b11) begin
            exp_q.push_back({op, 32'h0, 1'b1, 1'b0});
        end else begin
            iss_q.push_back({op, k, (op == 2'b00) ? v : 32'h0});
            if (to) begin
                exp_q.push_back({op, 32'h0, 1'b1, 1'b1});
            end else if (op == 2'b00) begin
                ref_map[k] = v;
                exp_q.push_back({op, 32'h0, 1'b0, 1'b0});
            end else if (op == 2'b01) begin
                if (ref_map.exists(k)) begin
                    ref_map.delete(k);
                    exp_q.push_back({op, 32'h0, 1'b0, 1'b0});
                end else begin
                    exp_q.push_back({op, 32'h0, 1'b1, 1'b0});
                end
            end else begin
                if (ref_map.exists(k)) exp_q.push_back({op, ref_map[k], 1'b0, 1'b0});
                else                   exp_q.push_back({op, 32'h0, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                        input bit to);
        int c = 0;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_key_i   = k;
        req_value_i = v;
        while (req_ready_o !== 1'b1 && c < 400) begin
            step();
            c++;
        end
        chk("req_accept", req_ready_o, 1'b1);
        ref_push(op, k, v, to);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input int n, input bit rnd);
        int   got = 0;
        int   c   = 0;
        exp_t e;
        while (got < n && c < 4000) begin
            rsp_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid_o === 1'b1 && rsp_ready_i) begin
                chk("rsp_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_op", rsp_op_o, e.op);
                    chk("rsp_value", rsp_value_o, e.val);
                    chk("rsp_error", rsp_error_o, e.err);
                    chk("rsp_timeout", rsp_timeout_o, e.to);
                end
                got++;
            end
            step();
            c++;
        end
        rsp_ready_i = 1'b0;
        chk("drain_count", got, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1'b1);
        chk({tag, "_ht_op_en"}, ht_op_en_o, 1'b0);
        chk({tag, "_ht_op_sel"}, ht_op_sel_o, 2'b00);
        chk({tag, "_ht_key"}, ht_key_o, 32'h0);
        chk({tag, "_ht_value"}, ht_value_o, 32'h0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
        chk({tag, "_rsp_op"}, rsp_op_o, 2'b00);
        chk({tag, "_rsp_value"}, rsp_value_o, 32'h0);
        chk({tag, "_rsp_error"}, rsp_error_o, 1'b0);
        chk({tag, "_rsp_timeout"}, rsp_timeout_o, 1'b0);
    endtask

    // Hash table model: answers each command strobe from its own key/value store.
    initial begin
        iss_t got, want;
        int   lat;
        ht_op_done_i   = 1'b0;
        ht_op_error_i  = 1'b0;
        ht_value_out_i = 32'h0;
        forever begin
            step();
            if (ht_op_en_o === 1'b1) begin
                got = {ht_op_sel_o, ht_key_o, ht_value_o};
                chk("issue_expected", iss_q.size() != 0, 1'b1);
                if (iss_q.size() != 0) begin
                    want = iss_q.pop_front();
                    chk("issue_fields", got, want);
                end
                if (!hm_never) begin
                    lat = (hm_lat == 0) ? int'($urandom_range(1, 4)) : hm_lat;
                    repeat (lat) @(posedge clk_i);
                    #1;
                    ht_value_out_i = $urandom;
                    ht_op_error_i  = 1'b0;
                    if (got.op == 2'b00) begin
                        hm_map[got.key] = got.val;
                    end else if (got.op == 2'b01) begin
                        if (hm_map.exists(got.key)) hm_map.delete(got.key);
                        else ht_op_error_i = 1'b1;
                    end else begin
                        if (hm_map.exists(got.key)) ht_value_out_i = hm_map[got.key];
                        else ht_op_error_i = 1'b1;
                    end
                    ht_op_done_i = 1'b1;
                    step();
                    ht_op_done_i  = 1'b0;
                    ht_op_error_i = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [1:0] op;
        int         r, c, n;
        bit         seen_en, seen_rsp;
        req_valid_i = 1'b0;
        req_op_i    = 2'b00;
        req_key_i   = 32'h0;
        req_value_i = 32'h0;
        rsp_ready_i = 1'b0;

        repeat (3) step();
        check_reset_outputs("reset");
        rst_i = 1'b0;
        step();
        check_reset_outputs("post_reset");

        // Insert: strobe exactly two cycles after acceptance, single pulse.
        hm_lat = 3;
        send(2'b00, 32'h10, 32'hAB, 1'b0);
        chk("ins_en_n1", ht_op_en_o, 1'b0);
        step();
        chk("ins_en_n2", ht_op_en_o, 1'b1);
        chk("ins_key", ht_key_o, 32'h10);
        chk("ins_value", ht_value_o, 32'hAB);
        step();
        chk("ins_en_n3", ht_op_en_o, 1'b0);
        chk("ins_key_hold", ht_key_o, 32'h10);
        drain(1, 1'b0);

        send(2'b10, 32'h10, 32'h0, 1'b0);
        drain(1, 1'b0);
        send(2'b10, 32'h99, 32'h0, 1'b0);
        drain(1, 1'b0);

        // Fill the queue while responses are back-pressured.
        hm_lat = 2;
        for (int i = 0; i < 4; i++) send(2'b00, 32'h20 + i, $urandom, 1'b0);
        chk("full_after_4", req_ready_o, 1'b0);
        fork
            send(2'b00, 32'h24, 32'h1234, 1'b0);
            begin
                repeat (3) begin
                    chk("full_hold", req_ready_o, 1'b0);
                    step();
                end
                drain(5, 1'b0);
            end
        join

        // Timeout, then a late done pulse that must be ignored.
        hm_never = 1'b1;
        send(2'b10, 32'h10, 32'h0, 1'b1);
        c = 0;
        while (ht_op_en_o !== 1'b1 && c < 10) begin
            step();
            c++;
        end
        chk("to_issue_seen", ht_op_en_o, 1'b1);
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("to_latency", n, TO + 1);
        chk("to_flag", rsp_timeout_o, 1'b1);
        ht_value_out_i = 32'h55;
        ht_op_done_i   = 1'b1;
        step();
        ht_op_done_i = 1'b0;
        chk("late_done_valid", rsp_valid_o, 1'b1);
        chk("late_done_value", rsp_value_o, 32'h0);
        chk("late_done_to", rsp_timeout_o, 1'b1);
        drain(1, 1'b0);
        ht_op_done_i = 1'b1;
        step();
        ht_op_done_i = 1'b0;
        step();
        chk("idle_done_ignored", rsp_valid_o, 1'b0);
        hm_never = 1'b0;
        send(2'b10, 32'h10, 32'h0, 1'b0);
        drain(1, 1'b0);

        // Illegal op: error response two cycles after acceptance, hash table untouched.
        send(2'b11, 32'h5, 32'h7, 1'b0);
        chk("ill_valid_n1", rsp_valid_o, 1'b0);
        step();
        chk("ill_valid_n2", rsp_valid_o, 1'b1);
        chk("ill_error", rsp_error_o, 1'b1);
        chk("ill_timeout", rsp_timeout_o, 1'b0);
        chk("ill_en", ht_op_en_o, 1'b0);
        drain(1, 1'b0);

        // Reset during WAIT with three entries queued.
        hm_never = 1'b1;
        send(2'b10, 32'h1, 32'h0, 1'b0);
        send(2'b10, 32'h2, 32'h0, 1'b0);
        send(2'b10, 32'h3, 32'h0, 1'b0);
        step();
        step();
        chk("pre_reset_busy", rsp_valid_o, 1'b0);
        rst_i = 1'b1;
        #2;
        check_reset_outputs("mid_reset");
        step();
        rst_i = 1'b0;
        exp_q.delete();
        iss_q.delete();
        hm_never = 1'b0;
        seen_en  = 1'b0;
        seen_rsp = 1'b0;
        repeat (20) begin
            step();
            seen_en  = seen_en | (ht_op_en_o === 1'b1);
            seen_rsp = seen_rsp | (rsp_valid_o === 1'b1);
        end
        chk("post_reset_no_en", seen_en, 1'b0);
        chk("post_reset_no_rsp", seen_rsp, 1'b0);
        chk("post_reset_ready", req_ready_o, 1'b1);

        // Random traffic with random hash latency and response back-pressure.
        hm_lat = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    r = $urandom_range(0, 9);
                    op = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                    send(op, $urandom_range(0, 7), $urandom, 1'b0);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            drain(40, 1'b1);
        join
        chk("final_rsp_queue_empty", exp_q.size(), 0);
        chk("final_issue_queue_empty", iss_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
